// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if: issue/retire handshakes plus the ALU operand/result bus
interface alu_sequencer_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
);
    logic                     in_valid;
    logic                     in_ready;
    logic [31:0]              instr;
    logic [DATA_WIDTH-1:0]    rs1_data;
    logic [DATA_WIDTH-1:0]    rs2_data;
    logic [DATA_WIDTH-1:0]    imm;
    logic [DATA_WIDTH-1:0]    SrcA;
    logic [DATA_WIDTH-1:0]    SrcB;
    logic [OPCODE_LENGTH-1:0] Operation;
    logic [DATA_WIDTH-1:0]    ALUResult;
    logic                     out_valid;
    logic                     out_ready;
    logic [DATA_WIDTH-1:0]    out_result;
    logic                     out_branch_taken;
    logic                     out_illegal;

    modport slave (
        input  in_valid, instr, rs1_data, rs2_data, imm, ALUResult, out_ready,
        output in_ready, SrcA, SrcB, Operation, out_valid, out_result, out_branch_taken, out_illegal
    );

    modport master (
        output in_valid, instr, rs1_data, rs2_data, imm, ALUResult, out_ready,
        input  in_ready, SrcA, SrcB, Operation, out_valid, out_result, out_branch_taken, out_illegal
    );
endinterface

// File: rtl/alu_sequencer.sv
// alu_sequencer: decodes one RV32I instruction, drives the ALU and holds its result for the consumer
module alu_sequencer #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input logic           clk,
    input logic           reset,
    alu_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t                   r_state;
    state_t                   w_next;
    logic [6:0]               w_opc;
    logic [2:0]               w_f3;
    logic [6:0]               w_f7;
    logic                     w_f7_zero;
    logic                     w_f7_alt;
    logic [OPCODE_LENGTH-1:0] w_op;
    logic                     w_legal;
    logic                     w_use_rs2;
    logic                     w_shift;
    logic                     w_is_branch;
    logic [DATA_WIDTH-1:0]    w_sel;
    logic [DATA_WIDTH-1:0]    w_srcb;
    logic [DATA_WIDTH-1:0]    r_srca;
    logic [DATA_WIDTH-1:0]    r_srcb;
    logic [DATA_WIDTH-1:0]    r_result;
    logic [OPCODE_LENGTH-1:0] r_op;
    logic                     r_branch;
    logic                     r_taken;
    logic                     r_illegal;

    assign w_opc     = bus.instr[6:0];
    assign w_f3      = bus.instr[14:12];
    assign w_f7      = bus.instr[31:25];
    assign w_f7_zero = w_f7 == 7'b0000000;
    assign w_f7_alt  = w_f7 == 7'b0100000;
    assign w_sel     = w_use_rs2 ? bus.rs2_data : bus.imm;
    assign w_srcb    = w_shift ? {{(DATA_WIDTH-5){1'b0}}, w_sel[4:0]} : w_sel;

    // instruction decode: ALU operation, legality and operand B source
    always_comb begin
        w_op        = 4'b0010;
        w_legal     = 1'b0;
        w_use_rs2   = 1'b0;
        w_shift     = 1'b0;
        w_is_branch = 1'b0;
        case (w_opc)
            7'b0110011: begin
                w_use_rs2 = 1'b1;
                case (w_f3)
                    3'b000: begin w_op = w_f7_alt ? 4'b0110 : 4'b0010; w_legal = w_f7_zero | w_f7_alt; end
                    3'b001: begin w_op = 4'b1001; w_legal = w_f7_zero; w_shift = 1'b1; end
                    3'b010: begin w_op = 4'b0111; w_legal = w_f7_zero; end
                    3'b100: begin w_op = 4'b0101; w_legal = w_f7_zero; end
                    3'b101: begin w_op = w_f7_alt ? 4'b0100 : 4'b1101; w_legal = w_f7_zero | w_f7_alt; w_shift = 1'b1; end
                    3'b110: begin w_op = 4'b0001; w_legal = w_f7_zero; end
                    3'b111: begin w_op = 4'b0000; w_legal = w_f7_zero; end
                    default: ;
                endcase
            end
            7'b0010011: begin
                case (w_f3)
                    3'b000: begin w_op = 4'b1100; w_legal = 1'b1; end
                    3'b001: begin w_op = 4'b1001; w_legal = w_f7_zero; w_shift = 1'b1; end
                    3'b010: begin w_op = 4'b0011; w_legal = 1'b1; end
                    3'b100: begin w_op = 4'b0101; w_legal = 1'b1; end
                    3'b101: begin w_op = w_f7_alt ? 4'b0100 : 4'b1101; w_legal = w_f7_zero | w_f7_alt; w_shift = 1'b1; end
                    3'b110: begin w_op = 4'b0001; w_legal = 1'b1; end
                    3'b111: begin w_op = 4'b0000; w_legal = 1'b1; end
                    default: ;
                endcase
            end
            7'b1100011: begin
                w_use_rs2   = 1'b1;
                w_is_branch = 1'b1;
                case (w_f3)
                    3'b000: begin w_op = 4'b1000; w_legal = 1'b1; end
                    3'b001: begin w_op = 4'b1110; w_legal = 1'b1; end
                    3'b100: begin w_op = 4'b1010; w_legal = 1'b1; end
                    3'b101: begin w_op = 4'b1011; w_legal = 1'b1; end
                    default: ;
                endcase
            end
            7'b0110111: begin w_op = 4'b1111; w_legal = 1'b1; end
            7'b0000011, 7'b0100011: w_legal = 1'b1;
            default: ;
        endcase
    end

    // state register; an illegal instruction skips EXEC and responds directly
    always_ff @(posedge clk) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = bus.in_valid ? (w_legal ? EXEC : RESP) : IDLE;
            EXEC:    w_next = RESP;
            RESP:    w_next = bus.out_ready ? IDLE : RESP;
            default: w_next = IDLE;
        endcase
    end

    // ALU inputs load on legal accept; result and flags load on EXEC or illegal accept and hold through RESP
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_srca    <= '0;
            r_srcb    <= '0;
            r_op      <= '0;
            r_result  <= '0;
            r_branch  <= 1'b0;
            r_taken   <= 1'b0;
            r_illegal <= 1'b0;
        end else if (r_state == IDLE && bus.in_valid) begin
            if (w_legal) begin
                r_srca    <= bus.rs1_data;
                r_srcb    <= w_srcb;
                r_op      <= w_op;
                r_branch  <= w_is_branch;
                r_taken   <= 1'b0;
                r_illegal <= 1'b0;
            end else begin
                r_result  <= '0;
                r_taken   <= 1'b0;
                r_illegal <= 1'b1;
            end
        end else if (r_state == EXEC) begin
            r_result <= bus.ALUResult;
            r_taken  <= r_branch & bus.ALUResult[0];
        end
    end

    assign bus.in_ready         = (r_state == IDLE) && reset;
    assign bus.out_valid        = r_state == RESP;
    assign bus.SrcA             = r_srca;
    assign bus.SrcB             = r_srcb;
    assign bus.Operation        = r_op;
    assign bus.out_result       = r_result;
    assign bus.out_branch_taken = r_taken;
    assign bus.out_illegal      = r_illegal;
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed vectors, reset corner cases and random instructions against a semantic model
module tb_alu_sequencer;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [3:0]  p_op = 4'h0;
    logic [31:0] p_a = 32'h0;
    logic [31:0] p_b = 32'h0;

    typedef struct packed {
        logic        legal;
        logic [3:0]  op;
        logic [31:0] srcb;
        logic [31:0] res;
        logic        taken;
    } exp_t;

    typedef struct {
        logic [31:0] ins;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] im;
        exp_t        e;
        int          stall;
    } vec_t;

    alu_sequencer_if #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) bus ();

    alu_sequencer #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // behavioural ALU sitting on the operand bus
    function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'd0:  return a & b;
            4'd1:  return a | b;
            4'd2:  return a + b;
            4'd3:  return {31'd0, $signed(a) < $signed(b)};
            4'd4:  return $unsigned($signed(a) >>> b[4:0]);
            4'd5:  return a ^ b;
            4'd6:  return a - b;
            4'd7:  return {31'd0, $signed(a) < $signed(b)};
            4'd8:  return {31'd0, a == b};
            4'd9:  return a << b[4:0];
            4'd10: return {31'd0, $signed(a) < $signed(b)};
            4'd11: return {31'd0, $signed(a) >= $signed(b)};
            4'd12: return a + b;
            4'd13: return a >> b[4:0];
            4'd14: return {31'd0, a != b};
            default: return b;
        endcase
    endfunction

    always_comb bus.ALUResult = alu_model(bus.Operation, bus.SrcA, bus.SrcB);

    function automatic exp_t mk(input logic [3:0] op, input logic [31:0] srcb, input logic [31:0] res);
        return '{legal: 1'b1, op: op, srcb: srcb, res: res, taken: 1'b0};
    endfunction

    // instruction semantics: what an RV32I core expects from this stage
    function automatic exp_t ref_model(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b, input logic [31:0] im);
        exp_t        e;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic        z;
        logic        alt;
        logic [4:0]  sr;
        logic [4:0]  si;
        logic        c;
        opc = ins[6:0];
        f3  = ins[14:12];
        z   = ins[31:25] == 7'h00;
        alt = ins[31:25] == 7'h20;
        sr  = b[4:0];
        si  = im[4:0];
        e   = '{legal: 1'b0, op: 4'h0, srcb: 32'h0, res: 32'h0, taken: 1'b0};
        case (opc)
            7'h33: case (f3)
                3'd0: if (z) e = mk(4'b0010, b, a + b); else if (alt) e = mk(4'b0110, b, a - b);
                3'd1: if (z) e = mk(4'b1001, {27'd0, sr}, a << sr);
                3'd2: if (z) e = mk(4'b0111, b, {31'd0, $signed(a) < $signed(b)});
                3'd4: if (z) e = mk(4'b0101, b, a ^ b);
                3'd5: if (z) e = mk(4'b1101, {27'd0, sr}, a >> sr); else if (alt) e = mk(4'b0100, {27'd0, sr}, $unsigned($signed(a) >>> sr));
                3'd6: if (z) e = mk(4'b0001, b, a | b);
                3'd7: if (z) e = mk(4'b0000, b, a & b);
                default: ;
            endcase
            7'h13: case (f3)
                3'd0: e = mk(4'b1100, im, a + im);
                3'd1: if (z) e = mk(4'b1001, {27'd0, si}, a << si);
                3'd2: e = mk(4'b0011, im, {31'd0, $signed(a) < $signed(im)});
                3'd4: e = mk(4'b0101, im, a ^ im);
                3'd5: if (z) e = mk(4'b1101, {27'd0, si}, a >> si); else if (alt) e = mk(4'b0100, {27'd0, si}, $unsigned($signed(a) >>> si));
                3'd6: e = mk(4'b0001, im, a | im);
                3'd7: e = mk(4'b0000, im, a & im);
                default: ;
            endcase
            7'h63: begin
                c = 1'b0;
                case (f3)
                    3'd0: begin c = a == b; e = mk(4'b1000, b, 32'h0); end
                    3'd1: begin c = a != b; e = mk(4'b1110, b, 32'h0); end
                    3'd4: begin c = $signed(a) < $signed(b); e = mk(4'b1010, b, 32'h0); end
                    3'd5: begin c = $signed(a) >= $signed(b); e = mk(4'b1011, b, 32'h0); end
                    default: ;
                endcase
                if (e.legal) begin
                    e.res   = {31'd0, c};
                    e.taken = c;
                end
            end
            7'h37: e = mk(4'b1111, im, im);
            7'h03, 7'h23: e = mk(4'b0010, im, a + im);
            default: ;
        endcase
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_ready();
        int w;
        w = 0;
        while (bus.in_ready !== 1'b1 && w < 8) begin
            @(negedge clk);
            w++;
        end
        if (bus.in_ready !== 1'b1) check("in_ready_timeout", {31'd0, bus.in_ready}, 32'd1);
    endtask

    task automatic do_txn(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b, input logic [31:0] im, input exp_t e, input int stall);
        wait_ready();
        bus.in_valid = 1'b1;
        bus.instr    = ins;
        bus.rs1_data = a;
        bus.rs2_data = b;
        bus.imm      = im;
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.instr     = $urandom;
        bus.rs1_data  = $urandom;
        bus.rs2_data  = $urandom;
        bus.imm       = $urandom;
        bus.out_ready = stall == 0;
        @(negedge clk);
        if (e.legal) begin
            check("exec_in_ready", {31'd0, bus.in_ready}, 32'd0);
            check("exec_out_valid", {31'd0, bus.out_valid}, 32'd0);
            check("exec_op", {28'd0, bus.Operation}, {28'd0, e.op});
            check("exec_srca", bus.SrcA, a);
            check("exec_srcb", bus.SrcB, e.srcb);
            p_op = e.op;
            p_a  = a;
            p_b  = e.srcb;
            @(negedge clk);
        end else begin
            check("illegal_op_kept", {28'd0, bus.Operation}, {28'd0, p_op});
            check("illegal_srca_kept", bus.SrcA, p_a);
            check("illegal_srcb_kept", bus.SrcB, p_b);
        end
        check("resp_valid", {31'd0, bus.out_valid}, 32'd1);
        check("resp_in_ready", {31'd0, bus.in_ready}, 32'd0);
        check("resp_result", bus.out_result, e.res);
        check("resp_taken", {31'd0, bus.out_branch_taken}, {31'd0, e.taken});
        check("resp_illegal", {31'd0, bus.out_illegal}, {31'd0, !e.legal});
        repeat (stall) begin
            @(negedge clk);
            check("stall_valid", {31'd0, bus.out_valid}, 32'd1);
            check("stall_result", bus.out_result, e.res);
            check("stall_taken", {31'd0, bus.out_branch_taken}, {31'd0, e.taken});
            check("stall_illegal", {31'd0, bus.out_illegal}, {31'd0, !e.legal});
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("retire_valid", {31'd0, bus.out_valid}, 32'd0);
        check("retire_in_ready", {31'd0, bus.in_ready}, 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd0);
        check({tag, "_out_valid"}, {31'd0, bus.out_valid}, 32'd0);
        check({tag, "_op"}, {28'd0, bus.Operation}, 32'd0);
        check({tag, "_srca"}, bus.SrcA, 32'd0);
        check({tag, "_srcb"}, bus.SrcB, 32'd0);
        check({tag, "_result"}, bus.out_result, 32'd0);
        check({tag, "_taken"}, {31'd0, bus.out_branch_taken}, 32'd0);
        check({tag, "_illegal"}, {31'd0, bus.out_illegal}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t        vecs[11];
        logic [6:0]  opcs[6];
        logic [6:0]  opc;
        logic [6:0]  f7;
        logic [31:0] ins;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] im;
        opcs = '{7'h33, 7'h13, 7'h63, 7'h37, 7'h03, 7'h23};
        vecs[0]  = '{32'h002081B3, 32'd5, 32'd7, 32'd0, '{1'b1, 4'b0010, 32'd7, 32'd12, 1'b0}, 0};
        vecs[1]  = '{32'h402081B3, 32'd5, 32'd7, 32'd0, '{1'b1, 4'b0110, 32'd7, 32'hFFFFFFFE, 1'b0}, 0};
        vecs[2]  = '{32'h4030D093, 32'h80000000, 32'h55, 32'hFFFFF403, '{1'b1, 4'b0100, 32'd3, 32'hF0000000, 1'b0}, 0};
        vecs[3]  = '{32'h00209463, 32'd1, 32'd2, 32'd0, '{1'b1, 4'b1110, 32'd2, 32'd1, 1'b1}, 5};
        vecs[4]  = '{32'h00208463, 32'h1234, 32'h1234, 32'd0, '{1'b1, 4'b1000, 32'h1234, 32'd1, 1'b1}, 0};
        vecs[5]  = '{32'h0000007F, 32'd9, 32'd9, 32'd9, '{1'b0, 4'b1000, 32'h1234, 32'd0, 1'b0}, 2};
        vecs[6]  = '{32'h123452B7, 32'd3, 32'd4, 32'h12345000, '{1'b1, 4'b1111, 32'h12345000, 32'h12345000, 1'b0}, 0};
        vecs[7]  = '{32'h002091B3, 32'd1, 32'h23, 32'd0, '{1'b1, 4'b1001, 32'd3, 32'd8, 1'b0}, 1};
        vecs[8]  = '{32'h0000A103, 32'h100, 32'd0, 32'hFFFFFFFC, '{1'b1, 4'b0010, 32'hFFFFFFFC, 32'hFC, 1'b0}, 0};
        vecs[9]  = '{32'h0020C463, 32'd5, 32'd3, 32'd0, '{1'b1, 4'b1010, 32'd3, 32'd0, 1'b0}, 0};
        vecs[10] = '{32'h0020B1B3, 32'd1, 32'd2, 32'd0, '{1'b0, 4'b1010, 32'd3, 32'd0, 1'b0}, 0};

        bus.in_valid  = 1'b1;
        bus.instr     = 32'h002081B3;
        bus.rs1_data  = 32'd5;
        bus.rs2_data  = 32'd7;
        bus.imm       = 32'd0;
        bus.out_ready = 1'b1;
        reset         = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check_all_zero("reset");
        end
        bus.in_valid = 1'b0;
        reset        = 1'b1;
        @(negedge clk);
        check("post_reset_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("post_reset_no_accept", {31'd0, bus.out_valid}, 32'd0);

        foreach (vecs[i]) do_txn(vecs[i].ins, vecs[i].a, vecs[i].b, vecs[i].im, vecs[i].e, vecs[i].stall);

        wait_ready();
        bus.in_valid = 1'b1;
        bus.instr    = 32'h002081B3;
        bus.rs1_data = 32'd40;
        bus.rs2_data = 32'd2;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        reset        = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("exec_reset_no_valid", {31'd0, bus.out_valid}, 32'd0);
        end
        check("exec_reset_op_cleared", {28'd0, bus.Operation}, 32'd0);
        check("exec_reset_result_cleared", bus.out_result, 32'd0);
        p_op = 4'h0;
        p_a  = 32'h0;
        p_b  = 32'h0;

        bus.in_valid = 1'b1;
        bus.instr    = 32'h0000007F;
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        check("resp_pre_reset_valid", {31'd0, bus.out_valid}, 32'd1);
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset         = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("resp_reset_no_valid", {31'd0, bus.out_valid}, 32'd0);
        check("resp_reset_illegal_cleared", {31'd0, bus.out_illegal}, 32'd0);
        check("resp_reset_in_ready", {31'd0, bus.in_ready}, 32'd1);

        repeat (250) begin
            int pick;
            pick = $urandom_range(0, 6);
            opc  = pick == 6 ? 7'($urandom) : opcs[pick];
            case ($urandom_range(0, 3))
                0, 1:    f7 = 7'h00;
                2:       f7 = 7'h20;
                default: f7 = 7'($urandom);
            endcase
            ins = {f7, 5'($urandom), 5'($urandom), 3'($urandom), 5'($urandom), opc};
            a   = $urandom;
            b   = $urandom_range(0, 3) == 0 ? a : $urandom;
            im  = $urandom;
            do_txn(ins, a, b, im, ref_model(ins, a, b, im), $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
